score_ctrl: RTL and testbench
=============================

Name: score_ctrl

Overview:
- Game-score sequencer for the dinosaur game.
- Owns the run/over state machine, the 13-bit running score, the high score and the speed level.
- Selects the value forwarded to the score display block, whose score input is 13 bits.
- Sits between the game-tick and collision sources and the display; the display is driven solely from disp_score.

Parameters:
- TICK_DIV, 4: tick pulses per score increment (>=1).
- SCORE_MAX, 6399: score saturation value; reaching it ends the game as a win (display capacity is 8x8 hundreds).
- SPEED_STEP, 100: score increments per speed-level step.
- BLINK_DIV, 8: tick pulses per display toggle in OVER (>=1).

Ports:
- clk2  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new game.
- tick  in  1  single-cycle game-time pulse.
- collide  in  1  level/pulse; obstacle hit.
- score  out  13  current score.
- hiscore  out  13  best score since reset.
- disp_score  out  13  value for the score display.
- speed  out  3  obstacle speed level, 0..7.
- running  out  1  high in RUN.
- game_over  out  1  high in OVER.
- win  out  1  high in OVER when the game ended by saturation.

Behaviour:
- All outputs and internal registers are registered.
- reset=1 at a clock edge:
  - state=IDLE;
  - score, hiscore, disp_score, speed = 0;
  - running, game_over, win = 0;
  - all counters = 0.
- reset overrides every other input and aborts any game mid-operation.
- States and transitions:
  - IDLE: disp_score=hiscore; start -> RUN.
  - RUN: count (below); collide -> OVER (win=0); increment reaching SCORE_MAX -> OVER (win=1).
  - OVER: score frozen; start -> RUN.
- Entry into RUN (same edge the start pulse is sampled):
  - score=0, speed=0;
  - tick prescaler=0, step counter=0;
  - win=0.
- Counting in RUN:
  - Prescaler counts sampled tick pulses.
  - On the TICK_DIV-th tick, the prescaler returns to 0 and score increments at that same edge. Visible one cycle after the tick is sampled.
  - Step counter increments with each score increment. On reaching SPEED_STEP it wraps to 0 and speed increments, saturating at 7.
  - speed therefore equals min(score/SPEED_STEP, 7) with no divider.
  - If score+1 == SCORE_MAX, score is loaded with SCORE_MAX, the state moves to OVER and win=1, all on that edge. score never exceeds SCORE_MAX.
- Collision:
  - collide sampled in RUN -> OVER on that edge.
  - An increment due on the same edge is discarded (collide wins).
  - collide ignored in IDLE and OVER.
  - start and collide together in RUN: collide wins; start is ignored.
- High score:
  - On the edge entering OVER, hiscore <= max(hiscore, final score), where final score is the value written to score on that edge.
  - hiscore is never cleared except by reset.
- Display in OVER:
  - Blink counter counts ticks. Every BLINK_DIV ticks it toggles phase.
  - phase 0: disp_score=score; phase 1: disp_score=hiscore.
  - phase=0 and blink counter=0 on OVER entry.
- disp_score in RUN = score, tracking it with the same-cycle registered value.
- start in RUN is ignored. start in OVER restarts immediately; hiscore is retained.
- The tick prescaler is frozen outside RUN.
- running and game_over are mutually exclusive and track state with no extra latency.

Test Plan:
- Reset then start; apply 8 tick pulses (TICK_DIV=4) -> score=2, disp_score=2, running=1.
- Run to score=99, then 4 ticks -> score=100, speed=1. Continue to 800 -> speed saturates at 7.
- At score=37, collide asserted on the same cycle as the 4th tick -> score stays 37, game_over=1, hiscore=37. 8 more ticks -> disp_score toggles to 37/hiscore; same value here. Second game ending at 20 -> hiscore stays 37 and disp_score alternates 20/37 every 8 ticks.
- Force score to 6398 in RUN, then 4 ticks -> score=6399, game_over=1, win=1, no further increments on more ticks.
- reset=1 mid-RUN at score=55 -> next edge: all outputs 0, state IDLE. start collide simultaneous in RUN -> OVER, not restart.
- start in OVER -> next edge: score=0, speed=0, win=0, running=1, hiscore unchanged.

Source files
------------

// File: rtl/score_ctrl_if.sv
// Control and display bundle of the dinosaur-game score sequencer.
// The game-tick/collision side drives start/tick/collide; the sequencer
// returns the score, high score, display value, speed and status flags.
interface score_ctrl_if;
  logic        start;
  logic        tick;
  logic        collide;
  logic [12:0] score;
  logic [12:0] hiscore;
  logic [12:0] disp_score;
  logic [2:0]  speed;
  logic        running;
  logic        game_over;
  logic        win;

  modport master (
    output start, tick, collide,
    input  score, hiscore, disp_score, speed, running, game_over, win
  );

  modport slave (
    input  start, tick, collide,
    output score, hiscore, disp_score, speed, running, game_over, win
  );
endinterface

// File: rtl/score_ctrl.sv
// Game-score sequencer: IDLE/RUN/OVER state machine, saturating 13-bit
// score, high score, speed level derived from a step counter, and the
// value shown on the score display (blinking score/hiscore once over).
module score_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int SCORE_MAX  = 6399,
  parameter int SPEED_STEP = 100,
  parameter int BLINK_DIV  = 8
) (
  input  logic         clk2,
  input  logic         reset,
  score_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int BW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(SPEED_STEP - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [12:0]   SCORE_TOP  = 13'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [12:0]   score_reg, score_next;
  logic [12:0]   hiscore_reg, hiscore_next;
  logic [12:0]   disp_reg, disp_next;
  logic [2:0]    speed_reg, speed_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [SW-1:0] step_reg, step_next;
  logic [BW-1:0] blink_reg, blink_next;
  logic          phase_reg, phase_next;
  logic          win_reg, win_next;
  logic          enter_run;
  logic          enter_over;

  // State and datapath registers; reset aborts any game in progress.
  always_ff @(posedge clk2) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      score_reg   <= '0;
      hiscore_reg <= '0;
      disp_reg    <= '0;
      speed_reg   <= '0;
      presc_reg   <= '0;
      step_reg    <= '0;
      blink_reg   <= '0;
      phase_reg   <= 1'b0;
      win_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      score_reg   <= score_next;
      hiscore_reg <= hiscore_next;
      disp_reg    <= disp_next;
      speed_reg   <= speed_next;
      presc_reg   <= presc_next;
      step_reg    <= step_next;
      blink_reg   <= blink_next;
      phase_reg   <= phase_next;
      win_reg     <= win_next;
    end
  end

  // Next-state logic: transitions, scoring, speed stepping, blinking, display select.
  always_comb begin
    state_next   = state_reg;
    score_next   = score_reg;
    hiscore_next = hiscore_reg;
    speed_next   = speed_reg;
    presc_next   = presc_reg;
    step_next    = step_reg;
    blink_next   = blink_reg;
    phase_next   = phase_reg;
    win_next     = win_reg;
    disp_next    = disp_reg;
    enter_run    = 1'b0;
    enter_over   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          enter_run = 1'b1;
        end
      end

      ST_RUN: begin
        // A collision discards any increment due on the same edge.
        if (bus.collide) begin
          enter_over = 1'b1;
        end else if (bus.tick) begin
          if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            if (step_reg == STEP_LAST) begin
              step_next = '0;
              if (speed_reg != 3'd7) begin
                speed_next = speed_reg + 3'd1;
              end
            end else begin
              step_next = step_reg + 1'b1;
            end
            if (score_reg + 13'd1 == SCORE_TOP) begin
              score_next = SCORE_TOP;
              win_next   = 1'b1;
              enter_over = 1'b1;
            end else begin
              score_next = score_reg + 13'd1;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (bus.start) begin
          enter_run = 1'b1;
        end else if (bus.tick) begin
          if (blink_reg == BLINK_LAST) begin
            blink_next = '0;
            phase_next = ~phase_reg;
          end else begin
            blink_next = blink_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (enter_run) begin
      state_next = ST_RUN;
      score_next = '0;
      speed_next = '0;
      presc_next = '0;
      step_next  = '0;
      win_next   = 1'b0;
    end

    // Final score is whatever is written to score on the entry edge.
    if (enter_over) begin
      state_next = ST_OVER;
      blink_next = '0;
      phase_next = 1'b0;
      if (score_next > hiscore_reg) begin
        hiscore_next = score_next;
      end
    end

    // Display follows next-state values so it is aligned with score/hiscore.
    case (state_next)
      ST_IDLE: disp_next = hiscore_next;
      ST_RUN:  disp_next = score_next;
      ST_OVER: disp_next = phase_next ? hiscore_next : score_next;
      default: disp_next = hiscore_next;
    endcase
  end

  assign bus.score      = score_reg;
  assign bus.hiscore    = hiscore_reg;
  assign bus.disp_score = disp_reg;
  assign bus.speed      = speed_reg;
  assign bus.running    = (state_reg == ST_RUN);
  assign bus.game_over  = (state_reg == ST_OVER);
  assign bus.win        = win_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: stimulus pushes the reference model's
// expected outputs per clock; a negedge monitor pops and compares them.
module tb_score_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int SCORE_MAX  = 6399;
  localparam int SPEED_STEP = 100;
  localparam int BLINK_DIV  = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic clk2;
  logic reset;
  score_ctrl_if bus ();

  score_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .SCORE_MAX (SCORE_MAX),
    .SPEED_STEP(SPEED_STEP),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk2 (clk2),
    .reset(reset),
    .bus  (bus)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  typedef struct {
    int score;
    int hiscore;
    int disp;
    int speed;
    int running;
    int game_over;
    int win;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Reference model: game described by ticks counted since the game began.
  int m_state = M_IDLE;
  int m_ticks = 0;
  int m_over_ticks = 0;
  int m_hi = 0;
  int m_win = 0;

  function automatic int m_score();
    int s;
    s = m_ticks / TICK_DIV;
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  task automatic go_over();
    m_state = M_OVER;
    m_over_ticks = 0;
    if (m_score() > m_hi) m_hi = m_score();
  endtask

  task automatic model(input bit r, input bit s, input bit t, input bit c);
    exp_t e;
    int   sc;
    if (r) begin
      m_state = M_IDLE; m_ticks = 0; m_over_ticks = 0; m_hi = 0; m_win = 0;
    end else begin
      case (m_state)
        M_IDLE: if (s) begin m_state = M_RUN; m_ticks = 0; m_win = 0; end
        M_RUN: begin
          if (c) go_over();
          else if (t) begin
            m_ticks++;
            if (m_ticks / TICK_DIV >= SCORE_MAX) begin
              m_win = 1;
              go_over();
            end
          end
        end
        default: begin
          if (s) begin m_state = M_RUN; m_ticks = 0; m_win = 0; end
          else if (t) m_over_ticks++;
        end
      endcase
    end
    sc = m_score();
    e.score     = sc;
    e.hiscore   = m_hi;
    e.speed     = (sc / SPEED_STEP > 7) ? 7 : sc / SPEED_STEP;
    e.running   = (m_state == M_RUN) ? 1 : 0;
    e.game_over = (m_state == M_OVER) ? 1 : 0;
    e.win       = m_win;
    if (m_state == M_IDLE)      e.disp = m_hi;
    else if (m_state == M_RUN)  e.disp = sc;
    else e.disp = (((m_over_ticks / BLINK_DIV) % 2) == 1) ? m_hi : sc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cycle, act, req);
    end
  endtask

  // Monitor: compare registered outputs against the oldest expectation.
  always @(negedge clk2) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("score",      int'(bus.score),      mon_e.score);
      chk("hiscore",    int'(bus.hiscore),    mon_e.hiscore);
      chk("disp_score", int'(bus.disp_score), mon_e.disp);
      chk("speed",      int'(bus.speed),      mon_e.speed);
      chk("running",    int'(bus.running),    mon_e.running);
      chk("game_over",  int'(bus.game_over),  mon_e.game_over);
      chk("win",        int'(bus.win),        mon_e.win);
    end
  end

  task automatic step(input bit r, input bit s, input bit t, input bit c);
    reset = r; bus.start = s; bus.tick = t; bus.collide = c;
    @(posedge clk2);
    cycle++;
    model(r, s, t, c);
    @(negedge clk2);
  endtask

  task automatic ticks(input int n);
    int done = 0;
    while (done < n) begin
      if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0);
      else begin step(0, 0, 1, 0); done++; end
    end
  endtask

  task automatic tick_until(input int target);
    for (int i = 0; i < 60000 && m_score() < target && m_state == M_RUN; i++) begin
      step(0, 0, ($urandom_range(0, 7) != 0), 0);
    end
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.tick = 1'b0; bus.collide = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("reset_score", int'(bus.score), 0);
    chk("reset_disp",  int'(bus.disp_score), 0);
    $display("reset: score=%0d running=%0d", bus.score, bus.running);

    step(0, 1, 0, 0);
    ticks(8);
    chk("tp_score2", int'(bus.score), 2);
    chk("tp_disp2",  int'(bus.disp_score), 2);
    chk("tp_run",    int'(bus.running), 1);
    $display("game1: 8 ticks score=%0d", bus.score);

    tick_until(99);
    ticks(4);
    chk("tp_score100", int'(bus.score), 100);
    chk("tp_speed1",   int'(bus.speed), 1);
    tick_until(800);
    chk("tp_speed7",   int'(bus.speed), 7);
    step(0, 0, 0, 1);
    $display("game1: collide at score=%0d speed=%0d", bus.score, bus.speed);

    step(0, 1, 0, 0);
    tick_until(55);
    step(1, 0, 1, 0);
    chk("rst_mid_score", int'(bus.score), 0);
    chk("rst_mid_hi",    int'(bus.hiscore), 0);
    chk("rst_mid_run",   int'(bus.running), 0);
    $display("reset mid-run: score=%0d hiscore=%0d", bus.score, bus.hiscore);

    step(0, 1, 0, 0);
    tick_until(37);
    ticks(3);
    step(0, 0, 1, 1);
    chk("col_score", int'(bus.score), 37);
    chk("col_over",  int'(bus.game_over), 1);
    chk("col_hi",    int'(bus.hiscore), 37);
    ticks(16);
    $display("game2: over at score=%0d hiscore=%0d", bus.score, bus.hiscore);

    step(0, 1, 0, 0);
    tick_until(20);
    step(0, 0, 0, 1);
    ticks(BLINK_DIV);
    chk("blink_hi",  int'(bus.disp_score), 37);
    ticks(BLINK_DIV);
    chk("blink_sc",  int'(bus.disp_score), 20);
    ticks(16);
    $display("game3: over at score=%0d hiscore=%0d", bus.score, bus.hiscore);

    step(0, 1, 0, 0);
    chk("restart_score", int'(bus.score), 0);
    chk("restart_run",   int'(bus.running), 1);
    chk("restart_hi",    int'(bus.hiscore), 37);
    tick_until(5);
    step(0, 1, 0, 1);
    chk("startcol_over", int'(bus.game_over), 1);
    chk("startcol_score", int'(bus.score), 5);
    $display("game4: start+collide -> over score=%0d", bus.score);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
    end
    $display("random phase done at cycle %0d", cycle);

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    tick_until(SCORE_MAX);
    chk("win_score", int'(bus.score), SCORE_MAX);
    chk("win_flag",  int'(bus.win), 1);
    chk("win_over",  int'(bus.game_over), 1);
    ticks(20);
    chk("win_frozen", int'(bus.score), SCORE_MAX);
    $display("win game: score=%0d hiscore=%0d", bus.score, bus.hiscore);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk2);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
